timer_ctrl: RTL and testbench

- Programmable, bus-mapped timer controller. Replaces the fixed millisecond tick with a software-configured prescaler, compare period, one-shot/periodic mode and a maskable, acknowledgeable interrupt.
- Sits on the Ceespu peripheral bus next to the interrupt logic.
- Drives O_irq as a level into the interrupt input and O_pulse as a one-cycle strobe for other peripherals.

---
 rtl/timer_ctrl.sv | 143 ++++++++++++++
 tb/tb_timer_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// Bus-mapped timer: prescaler plus compare counter with one-shot/periodic mode and a maskable, acknowledgeable irq.
// Reads return data one cycle after I_re; writes take effect on the strobe edge; there is no backpressure.
module timer_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic [1:0]            I_addr,
  input  logic                  I_we,
  input  logic                  I_re,
  input  logic [DATA_WIDTH-1:0] I_wdata,
  output logic [DATA_WIDTH-1:0] O_rdata,
  output logic                  O_irq,
  output logic                  O_pulse
);

  typedef enum logic {STOP = 1'b0, RUN = 1'b1} state_t;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_PRESCALE = 2'd1;
  localparam logic [1:0] ADDR_COMPARE  = 2'd2;
  localparam logic [1:0] ADDR_COUNT    = 2'd3;

  localparam logic [PRESCALE_WIDTH-1:0] P_ONE = PRESCALE_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0]     C_ONE = DATA_WIDTH'(1);

  state_t                    state_q, state_d;
  logic                      reload_q, reload_d;
  logic                      irq_en_q, irq_en_d;
  logic                      pending_q, pending_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [PRESCALE_WIDTH-1:0] p_q, p_d;
  logic [DATA_WIDTH-1:0]     compare_q, compare_d;
  logic [DATA_WIDTH-1:0]     count_q, count_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      irq_q, irq_d;
  logic                      pulse_q, pulse_d;

  logic run, tick, match;
  logic wr_ctrl, wr_prescale, wr_compare, wr_ack;

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q    <= STOP;
      reload_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      pending_q  <= 1'b0;
      prescale_q <= '0;
      p_q        <= '0;
      compare_q  <= '0;
      count_q    <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      reload_q   <= reload_d;
      irq_en_q   <= irq_en_d;
      pending_q  <= pending_d;
      prescale_q <= prescale_d;
      p_q        <= p_d;
      compare_q  <= compare_d;
      count_q    <= count_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
      pulse_q    <= pulse_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    reload_d   = reload_q;
    irq_en_d   = irq_en_q;
    pending_d  = pending_q;
    prescale_d = prescale_q;
    p_d        = p_q;
    compare_d  = compare_q;
    count_d    = count_q;
    rdata_d    = rdata_q;

    run         = (state_q == RUN);
    tick        = run && (p_q == prescale_q);
    match       = tick && (count_q == compare_q);
    wr_ctrl     = I_we && (I_addr == ADDR_CTRL);
    wr_prescale = I_we && (I_addr == ADDR_PRESCALE);
    wr_compare  = I_we && (I_addr == ADDR_COMPARE);
    wr_ack      = I_we && (I_addr == ADDR_COUNT) && I_wdata[0];

    if (run) begin
      p_d = tick ? '0 : p_q + P_ONE;
      if (tick) begin
        count_d = match ? '0 : count_q + C_ONE;
      end
    end

    if (match && !reload_q) begin
      state_d = STOP;
    end

    // A CTRL write outranks the one-shot stop landing on the same edge.
    if (wr_ctrl) begin
      state_d  = I_wdata[0] ? RUN : STOP;
      reload_d = I_wdata[1];
      irq_en_d = I_wdata[2];
    end

    if (wr_prescale) begin
      prescale_d = I_wdata[PRESCALE_WIDTH-1:0];
    end
    if (wr_compare) begin
      compare_d = I_wdata;
    end
    if (wr_prescale || wr_compare) begin
      p_d     = '0;
      count_d = '0;
    end

    // Set beats clear when a match and an ACK coincide.
    if (match) begin
      pending_d = 1'b1;
    end else if (wr_ack) begin
      pending_d = 1'b0;
    end

    if (I_re) begin
      case (I_addr)
        ADDR_CTRL:     rdata_d = {{(DATA_WIDTH-4){1'b0}}, pending_q, irq_en_q, reload_q, run};
        ADDR_PRESCALE: rdata_d = {{(DATA_WIDTH-PRESCALE_WIDTH){1'b0}}, prescale_q};
        ADDR_COMPARE:  rdata_d = compare_q;
        default:       rdata_d = count_q;
      endcase
    end

    pulse_d = match;
    irq_d   = pending_q && irq_en_q;
  end

  assign O_rdata = rdata_q;
  assign O_irq   = irq_q;
  assign O_pulse = pulse_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_timer_ctrl;

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b1;
  logic [1:0]  I_addr = '0;
  logic        I_we = 1'b0;
  logic        I_re = 1'b0;
  logic [31:0] I_wdata = '0;
  logic [31:0] O_rdata;
  logic        O_irq;
  logic        O_pulse;

  int n_pass = 0;
  int n_total = 0;

  timer_ctrl #(.DATA_WIDTH(32), .PRESCALE_WIDTH(16)) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_addr(I_addr), .I_we(I_we), .I_re(I_re),
    .I_wdata(I_wdata), .O_rdata(O_rdata), .O_irq(O_irq), .O_pulse(O_pulse)
  );

  always #5 I_clk = ~I_clk;

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    I_addr = a; I_wdata = d; I_we = 1'b1;
    @(negedge I_clk);
    I_we = 1'b0; I_wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    I_addr = a; I_re = 1'b1;
    @(negedge I_clk);
    I_re = 1'b0;
    d = O_rdata;
  endtask

  task automatic do_reset();
    @(negedge I_clk);
    I_rst = 1'b1;
    @(negedge I_clk);
    I_rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    n_total++;
    if ({O_rdata, O_irq, O_pulse} !== 34'd0) $display("FAIL reset_outputs got rdata=%h irq=%b pulse=%b want all 0", O_rdata, O_irq, O_pulse);
    else n_pass++;
    rd(2'd0, v);
    n_total++;
    if (v !== 32'h0) $display("FAIL reset_ctrl got %h want 0", v); else n_pass++;
    rd(2'd3, v);
    n_total++;
    if (v !== 32'h0) $display("FAIL reset_count got %h want 0", v); else n_pass++;
  endtask

  task automatic test_regs();
    logic [31:0] v;
    wr(2'd1, 32'hFFFF_1234);
    rd(2'd1, v);
    n_total++;
    if (v !== 32'h0000_1234) $display("FAIL reg_prescale got %h want 00001234", v); else n_pass++;
    wr(2'd2, 32'hDEAD_BEEF);
    rd(2'd2, v);
    n_total++;
    if (v !== 32'hDEAD_BEEF) $display("FAIL reg_compare got %h want deadbeef", v); else n_pass++;
    wr(2'd0, 32'hFFFF_FFF6);
    rd(2'd0, v);
    n_total++;
    if (v !== 32'h0000_0006) $display("FAIL reg_ctrl got %h want 00000006", v); else n_pass++;
    do_reset();
  endtask

  task automatic test_periodic();
    logic [31:0] v;
    logic [31:0] exp_cnt [6] = '{0, 1, 2, 3, 4, 0};
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd4);
    wr(2'd0, 32'h7);
    for (int i = 0; i < 6; i++) begin
      rd(2'd3, v);
      n_total++;
      if (v !== exp_cnt[i]) $display("FAIL periodic_count[%0d] got %0d want %0d", i, v, exp_cnt[i]); else n_pass++;
      n_total++;
      if (O_pulse !== (i == 4)) $display("FAIL periodic_pulse[%0d] got %b want %b", i, O_pulse, (i == 4)); else n_pass++;
      n_total++;
      if (O_irq !== (i >= 5)) $display("FAIL periodic_irq[%0d] got %b want %b", i, O_irq, (i >= 5)); else n_pass++;
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge I_clk);
      n_total++;
      if (O_pulse !== (j == 3)) $display("FAIL periodic_pulse2[%0d] got %b want %b", j, O_pulse, (j == 3)); else n_pass++;
    end
    do_reset();
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    int n;
    int pulses;
    wr(2'd1, 32'd3);
    wr(2'd2, 32'd2);
    wr(2'd0, 32'h5);
    n = 0;
    while (n < 40) begin
      @(negedge I_clk);
      n++;
      if (O_pulse) break;
    end
    n_total++;
    if (n !== 12) $display("FAIL oneshot_latency got %0d cycles want 12", n); else n_pass++;
    rd(2'd0, v);
    n_total++;
    if (v !== 32'hC) $display("FAIL oneshot_ctrl got %h want c", v); else n_pass++;
    rd(2'd3, v);
    n_total++;
    if (v !== 32'h0) $display("FAIL oneshot_count got %h want 0", v); else n_pass++;
    pulses = 0;
    repeat (100) begin
      @(negedge I_clk);
      if (O_pulse) pulses++;
    end
    n_total++;
    if (pulses !== 0) $display("FAIL oneshot_extra_pulses got %0d want 0", pulses); else n_pass++;
    n_total++;
    if (O_irq !== 1'b1) $display("FAIL oneshot_irq got %b want 1", O_irq); else n_pass++;
  endtask

  task automatic test_ack();
    logic [31:0] v;
    // Plain ACK on the pending left by the one-shot.
    wr(2'd3, 32'h1);
    n_total++;
    if (O_irq !== 1'b1) $display("FAIL ack_irq_same got %b want 1", O_irq); else n_pass++;
    @(negedge I_clk);
    n_total++;
    if (O_irq !== 1'b0) $display("FAIL ack_irq_next got %b want 0", O_irq); else n_pass++;
    do_reset();
    // ACK landing on the second match of a 5-cycle period.
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd4);
    wr(2'd0, 32'h7);
    repeat (9) @(negedge I_clk);
    wr(2'd3, 32'h1);
    n_total++;
    if (O_pulse !== 1'b1) $display("FAIL race_pulse got %b want 1", O_pulse); else n_pass++;
    @(negedge I_clk);
    n_total++;
    if (O_irq !== 1'b1) $display("FAIL race_irq got %b want 1", O_irq); else n_pass++;
    rd(2'd0, v);
    n_total++;
    if (v !== 32'hF) $display("FAIL race_ctrl got %h want f", v); else n_pass++;
    do_reset();
  endtask

  task automatic test_mask();
    logic [31:0] v;
    int n;
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd1);
    wr(2'd0, 32'h1);
    n = 0;
    while (n < 20) begin
      @(negedge I_clk);
      n++;
      if (O_pulse) break;
    end
    n_total++;
    if (n !== 2) $display("FAIL mask_pulse_latency got %0d want 2", n); else n_pass++;
    repeat (3) @(negedge I_clk);
    n_total++;
    if (O_irq !== 1'b0) $display("FAIL mask_irq got %b want 0", O_irq); else n_pass++;
    rd(2'd0, v);
    n_total++;
    if (v !== 32'h8) $display("FAIL mask_ctrl got %h want 8", v); else n_pass++;
    wr(2'd0, 32'h7);
    n_total++;
    if (O_irq !== 1'b0) $display("FAIL unmask_irq_same got %b want 0", O_irq); else n_pass++;
    @(negedge I_clk);
    n_total++;
    if (O_irq !== 1'b1) $display("FAIL unmask_irq_next got %b want 1", O_irq); else n_pass++;
    do_reset();
  endtask

  task automatic test_ctrl_race();
    logic [31:0] v;
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd2);
    wr(2'd0, 32'h1);
    repeat (2) @(negedge I_clk);
    wr(2'd0, 32'h1);
    n_total++;
    if (O_pulse !== 1'b1) $display("FAIL ctrl_race_pulse got %b want 1", O_pulse); else n_pass++;
    rd(2'd0, v);
    n_total++;
    if (v !== 32'h9) $display("FAIL ctrl_race_ctrl got %h want 9", v); else n_pass++;
    do_reset();
  endtask

  task automatic test_restart_halt();
    logic [31:0] v;
    int k;
    int pulses;
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd4);
    wr(2'd0, 32'h3);
    repeat (3) @(negedge I_clk);
    wr(2'd2, 32'd9);
    rd(2'd3, v);
    n_total++;
    if (v !== 32'd0) $display("FAIL restart_count got %0d want 0", v); else n_pass++;
    k = 1;
    while (k < 40 && !O_pulse) begin
      @(negedge I_clk);
      k++;
    end
    n_total++;
    if (k !== 10) $display("FAIL restart_period got %0d want 10", k); else n_pass++;
    repeat (3) @(negedge I_clk);
    wr(2'd0, 32'h0);
    rd(2'd3, v);
    n_total++;
    if (v !== 32'd4) $display("FAIL halt_count got %0d want 4", v); else n_pass++;
    repeat (5) @(negedge I_clk);
    rd(2'd3, v);
    n_total++;
    if (v !== 32'd4) $display("FAIL halt_frozen got %0d want 4", v); else n_pass++;
    wr(2'd0, 32'h3);
    rd(2'd3, v);
    n_total++;
    if (v !== 32'd4) $display("FAIL resume_first got %0d want 4", v); else n_pass++;
    rd(2'd3, v);
    n_total++;
    if (v !== 32'd5) $display("FAIL resume_second got %0d want 5", v); else n_pass++;
    // Reset between edges, mid-period, while O_rdata is nonzero.
    @(negedge I_clk);
    #2 I_rst = 1'b1;
    #1;
    n_total++;
    if ({O_rdata, O_irq, O_pulse} !== 34'd0) $display("FAIL async_reset got rdata=%h irq=%b pulse=%b want all 0", O_rdata, O_irq, O_pulse);
    else n_pass++;
    pulses = 0;
    repeat (20) begin
      @(negedge I_clk);
      if (O_pulse) pulses++;
    end
    I_rst = 1'b0;
    repeat (30) begin
      @(negedge I_clk);
      if (O_pulse || O_irq) pulses++;
    end
    n_total++;
    if (pulses !== 0) $display("FAIL reset_no_pulse got %0d want 0", pulses); else n_pass++;
    rd(2'd3, v);
    n_total++;
    if (v !== 32'd0) $display("FAIL reset_count_after got %0d want 0", v); else n_pass++;
  endtask

  initial begin
    @(negedge I_clk);
    I_rst = 1'b0;
    test_reset();
    test_regs();
    test_periodic();
    test_oneshot();
    test_ack();
    test_mask();
    test_ctrl_race();
    test_restart_halt();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
